uart_word_receiver: RTL and testbench
=====================================

Name: uart_word_receiver

Overview:
- Host/bench-side counterpart to `debugger`'s UART transmit path.
- Deserializes the 8N1 byte stream on the debugger's `tx_out` and reassembles DATA_WIDTH-bit words, first byte received into the MSB.
- Used in testbenches and loopback builds to check the `data_in` snapshot the debugger sends.
- Reports per-byte strobes, word strobes and framing errors.

Parameters:
- DIVIDER_TICKS, 1023: clk_in cycles per UART bit. Must match the `debugger` instance. Must be >= 4.
- DATA_WIDTH, 24: reassembled word width. Must be a nonzero multiple of 8.
- IDLE_TIMEOUT_BITS, 20: bit-times of line idle after which a partial word is discarded. 0 disables the timeout.

Ports:
- clk_in  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- rx_in  input  1  asynchronous UART line; idles high.
- byte_out  output  8  last good byte.
- byte_valid  output  1  one-cycle strobe; byte_out is valid.
- word_out  output  DATA_WIDTH  last complete word.
- word_valid  output  1  one-cycle strobe; word_out is valid.
- framing_error  output  1  one-cycle strobe; stop bit was sampled low.
- byte_index  output  $clog2(DATA_WIDTH/8)+1  bytes held in the current partial word.
- busy  output  1  high while not in IDLE.

Behaviour:
- Clocking and reset
  - Single clock domain; reset is synchronous and active-high, sampled only on posedge clk_in.
  - On reset: all outputs 0; state IDLE; bit counter 0; synchronizer flops 1.
  - Reset asserted mid-frame abandons the frame; nothing is emitted.
- Input synchronization: rx_in passes through a 2-flop synchronizer. All decisions use the synchronized value `rx_s`, so there are 2 cycles of input latency.
- Tick counter: width $clog2(DIVIDER_TICKS+1). Reloads on every state entry and decrements to 0.
- State machine
  - IDLE: when rx_s == 0, load the counter with DIVIDER_TICKS/2 (integer divide) and go to START.
  - START: at count 0, if rx_s == 0, load DIVIDER_TICKS, set bit_cnt = 0, go to DATA. If rx_s == 1, treat as a glitch: return to IDLE with no output.
  - DATA: at count 0, shift rx_s in LSB first (shreg <= {rx_s, shreg[7:1]}) and reload DIVIDER_TICKS. After the 8th sample, go to STOP.
  - STOP: at count 0, sample rx_s.
    - If 1: byte_valid = 1 on the next cycle, byte_out = shreg.
    - If 0: framing_error = 1 on the next cycle, the byte is discarded, and byte_index clears to 0.
    - Either way, return to IDLE. A new start bit is accepted on the cycle IDLE is re-entered, so zero idle between frames is supported.
- Word assembly
  - Each good byte does word_acc <= {word_acc[DATA_WIDTH-9:0], byte}. byte_index increments.
  - When byte_index reaches DATA_WIDTH/8:
    - word_out <= assembled value;
    - word_valid asserts in the same cycle as that byte's byte_valid;
    - byte_index <= 0.
  - For DATA_WIDTH == 8, every byte is also a word.
- Idle timeout
  - An idle counter runs in IDLE while byte_index != 0. It clears on leaving IDLE or on byte_index == 0.
  - When it reaches IDLE_TIMEOUT_BITS*DIVIDER_TICKS, byte_index <= 0 and word_acc <= 0. No strobe is produced.
  - Counter width is sized to IDLE_TIMEOUT_BITS*DIVIDER_TICKS.
- Simultaneous events: a timeout expiry and a start-bit detection in the same cycle resolve in favour of the start bit; the partial word is retained.
- Strobes: never high for more than one cycle. byte_valid and framing_error are mutually exclusive.
- word_out and byte_out hold their values between strobes.

Decomposition:
- Shared package `debug_pkg`: state enum (IDLE, START, DATA, STOP) and `UART_BITS = 8`.
- Sub-module `uart_byte_rx`: synchronizer, tick counter, FSM; outputs byte/byte_valid/framing_error/busy.
- Top level `uart_word_receiver`: word assembly and idle timeout.

Test Plan:
1. DIVIDER_TICKS=16, DATA_WIDTH=24: send bytes 0xF0, 0xAA, 0x0D at 16 clk/bit -> three byte_valid pulses; word_valid with word_out = 24'hF0AA0D; byte_index returns to 0.
2. Loopback: `debugger` (DIVIDER_TICKS=16) driving rx_in with data_in = 24'b111100001010101000001101 -> word_out = 24'hF0AA0D matches data_in.
3. Glitch: rx_in low for 3 cycles, then high -> state returns to IDLE; no byte_valid and no framing_error.
4. Framing error: send 0x11 with the stop bit forced low, after one good byte 0x22 -> framing_error pulse; byte_index = 0; next bytes 0x33, 0x44, 0x55 give word_out = 24'h334455.
5. Timeout: send 0x11, 0x22, then 20 bit-times idle, then 0xAB, 0xCD, 0xEF -> no word for 0x1122; word_out = 24'hABCDEF.
6. Reset mid-frame: assert reset during bit 4 of byte 0x5A -> all outputs 0 on the next cycle; a subsequent back-to-back 0x01, 0x02, 0x03 with zero inter-frame idle gives word_out = 24'h010203.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared definitions for the debugger UART path: receiver FSM states and frame geometry.
package debug_pkg;

  localparam int unsigned UART_BITS = 8;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: 2-flop synchronizer, per-bit tick counter and framing FSM.
module uart_byte_rx
  import debug_pkg::*;
#(
  parameter int unsigned DIVIDER_TICKS = 1023
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [UART_BITS-1:0] byte_out,
  output logic                 byte_valid,
  output logic                 framing_error,
  output logic                 busy,
  // Same-cycle events for the word assembler, one cycle ahead of the strobes
  output logic                 start_det,
  output logic                 byte_done,
  output logic                 stop_bad,
  output logic [UART_BITS-1:0] shreg
);

  localparam int unsigned CW = $clog2(DIVIDER_TICKS + 1);
  // Loaded with ticks-1 so the sample interval is exactly DIVIDER_TICKS cycles
  localparam logic [CW-1:0] HalfLoad = CW'(DIVIDER_TICKS / 2 - 1);
  localparam logic [CW-1:0] FullLoad = CW'(DIVIDER_TICKS - 1);

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [UART_BITS-1:0] shreg_q, shreg_d;
  logic [UART_BITS-1:0] byte_q, byte_d;
  logic                 byte_valid_q, byte_valid_d;
  logic                 framing_error_q, framing_error_d;
  logic                 rx_meta_q, rx_s_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      rx_meta_q       <= 1'b1;
      rx_s_q          <= 1'b1;
      state_q         <= StIdle;
      cnt_q           <= '0;
      bit_cnt_q       <= '0;
      shreg_q         <= '0;
      byte_q          <= '0;
      byte_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      rx_meta_q       <= rx_in;
      rx_s_q          <= rx_meta_q;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      shreg_q         <= shreg_d;
      byte_q          <= byte_d;
      byte_valid_q    <= byte_valid_d;
      framing_error_q <= framing_error_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    bit_cnt_d       = bit_cnt_q;
    shreg_d         = shreg_q;
    byte_d          = byte_q;
    byte_valid_d    = 1'b0;
    framing_error_d = 1'b0;
    start_det       = 1'b0;
    byte_done       = 1'b0;
    stop_bad        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          start_det = 1'b1;
          cnt_d     = HalfLoad;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rx_s_q) begin
          cnt_d     = FullLoad;
          bit_cnt_d = '0;
          state_d   = StData;
        end else begin
          state_d = StIdle;
        end
      end
      StData: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shreg_d   = {rx_s_q, shreg_q[UART_BITS-1:1]};
          cnt_d     = FullLoad;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(UART_BITS - 1)) state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = StIdle;
          if (rx_s_q) begin
            byte_done    = 1'b1;
            byte_valid_d = 1'b1;
            byte_d       = shreg_q;
          end else begin
            stop_bad        = 1'b1;
            framing_error_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign byte_out      = byte_q;
  assign byte_valid    = byte_valid_q;
  assign framing_error = framing_error_q;
  assign busy          = (state_q != StIdle);
  assign shreg         = shreg_q;

endmodule

// File: rtl/uart_word_receiver.sv
// Reassembles received UART bytes into DATA_WIDTH-bit words (first byte in the MSB),
// discarding a partial word after a long idle gap.
module uart_word_receiver
  import debug_pkg::*;
#(
  parameter int unsigned DIVIDER_TICKS     = 1023,
  parameter int unsigned DATA_WIDTH        = 24,
  parameter int unsigned IDLE_TIMEOUT_BITS = 20
) (
  input  logic                                clk_in,
  input  logic                                reset,
  input  logic                                rx_in,
  output logic [UART_BITS-1:0]                byte_out,
  output logic                                byte_valid,
  output logic [DATA_WIDTH-1:0]               word_out,
  output logic                                word_valid,
  output logic                                framing_error,
  output logic [$clog2(DATA_WIDTH/8):0]       byte_index,
  output logic                                busy
);

  localparam int unsigned NumBytes  = DATA_WIDTH / 8;
  localparam int unsigned IW        = $clog2(NumBytes) + 1;
  localparam int unsigned Limit     = IDLE_TIMEOUT_BITS * DIVIDER_TICKS;
  localparam bit          TimeoutEn = (Limit != 0);
  localparam int unsigned TW        = TimeoutEn ? $clog2(Limit + 1) : 1;

  logic                  start_det, byte_done, stop_bad;
  logic [UART_BITS-1:0]  shreg;
  logic [DATA_WIDTH-1:0] acc_shift;

  logic [DATA_WIDTH-1:0] word_acc_q, word_acc_d;
  logic [DATA_WIDTH-1:0] word_out_q, word_out_d;
  logic                  word_valid_q, word_valid_d;
  logic [IW-1:0]         byte_index_q, byte_index_d;
  logic [TW-1:0]         idle_cnt_q, idle_cnt_d;

  uart_byte_rx #(
    .DIVIDER_TICKS(DIVIDER_TICKS)
  ) u_byte_rx (
    .clk_in        (clk_in),
    .reset         (reset),
    .rx_in         (rx_in),
    .byte_out      (byte_out),
    .byte_valid    (byte_valid),
    .framing_error (framing_error),
    .busy          (busy),
    .start_det     (start_det),
    .byte_done     (byte_done),
    .stop_bad      (stop_bad),
    .shreg         (shreg)
  );

  always_ff @(posedge clk_in) begin
    if (reset) begin
      word_acc_q   <= '0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
      byte_index_q <= '0;
      idle_cnt_q   <= '0;
    end else begin
      word_acc_q   <= word_acc_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
      byte_index_q <= byte_index_d;
      idle_cnt_q   <= idle_cnt_d;
    end
  end

  // Shift form rather than a part-select so DATA_WIDTH == 8 needs no special case
  assign acc_shift = (word_acc_q << 8) | DATA_WIDTH'(shreg);

  always_comb begin
    word_acc_d   = word_acc_q;
    word_out_d   = word_out_q;
    word_valid_d = 1'b0;
    byte_index_d = byte_index_q;
    idle_cnt_d   = idle_cnt_q;

    if (byte_done) begin
      word_acc_d = acc_shift;
      if (byte_index_q == IW'(NumBytes - 1)) begin
        word_out_d   = acc_shift;
        word_valid_d = 1'b1;
        byte_index_d = '0;
      end else begin
        byte_index_d = byte_index_q + 1'b1;
      end
    end else if (stop_bad) begin
      byte_index_d = '0;
    end

    // A start bit in the expiry cycle wins and keeps the partial word
    if (!TimeoutEn || busy || start_det || byte_index_q == '0) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q == TW'(Limit)) begin
      idle_cnt_d   = '0;
      byte_index_d = '0;
      word_acc_d   = '0;
    end else begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
  assign byte_index = byte_index_q;

endmodule

// File: tb/tb_uart_word_receiver.sv
// Directed and randomized 8N1 frames against a byte-list reference model of word assembly.
module tb_uart_word_receiver;

  localparam int DIV   = 16;
  localparam int DW    = 24;
  localparam int TO    = 20;
  localparam int NB    = DW / 8;
  localparam int IW    = $clog2(NB) + 1;
  localparam int LONG  = TO + 5;

  logic          tb_clk_baudrate = 1'b0;
  logic          reset;
  logic          rx;
  logic [7:0]    byte_out;
  logic          byte_valid;
  logic [DW-1:0] word_out;
  logic          word_valid;
  logic          framing_error;
  logic [IW-1:0] byte_index;
  logic          busy;

  uart_word_receiver #(
    .DIVIDER_TICKS     (DIV),
    .DATA_WIDTH        (DW),
    .IDLE_TIMEOUT_BITS (TO)
  ) dut (
    .clk_in        (tb_clk_baudrate),
    .reset         (reset),
    .rx_in         (rx),
    .byte_out      (byte_out),
    .byte_valid    (byte_valid),
    .word_out      (word_out),
    .word_valid    (word_valid),
    .framing_error (framing_error),
    .byte_index    (byte_index),
    .busy          (busy)
  );

  always #5 tb_clk_baudrate = ~tb_clk_baudrate;

  int errors = 0;
  int checks = 0;

  // Observer: the only writer of these; the main block reads them relative to a base index
  logic [7:0]    obs_bytes[$];
  logic [DW-1:0] obs_words[$];
  int            fe_cnt = 0;
  int            overlap_cnt = 0;
  int            long_cnt = 0;
  logic          bv_prev = 1'b0, wv_prev = 1'b0, fe_prev = 1'b0;

  always @(negedge tb_clk_baudrate) begin
    if (byte_valid) obs_bytes.push_back(byte_out);
    if (word_valid) obs_words.push_back(word_out);
    if (framing_error) fe_cnt <= fe_cnt + 1;
    if (byte_valid && framing_error) overlap_cnt <= overlap_cnt + 1;
    if ((byte_valid && bv_prev) || (word_valid && wv_prev) || (framing_error && fe_prev))
      long_cnt <= long_cnt + 1;
    bv_prev <= byte_valid;
    wv_prev <= word_valid;
    fe_prev <= framing_error;
  end

  // Reference model: bytes of the current partial word, oldest first
  logic [7:0] mdl_bytes[$];

  function automatic logic [DW-1:0] pack_word();
    logic [DW-1:0] acc = '0;
    foreach (mdl_bytes[i]) acc = (acc << 8) | DW'(mdl_bytes[i]);
    return acc;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (DIV) @(negedge tb_clk_baudrate);
  endtask

  task automatic idle_bits(input int n);
    repeat (n) drive_bit(1'b1);
  endtask

  // Send one frame, compare the resulting events with the model, then idle for gap bit-times
  task automatic do_frame(input string tag, input logic [7:0] b, input bit good, input int gap);
    int            b_base, w_base, f_base;
    logic [DW-1:0] exp_word;
    bit            word_due;
    b_base = obs_bytes.size();
    w_base = obs_words.size();
    f_base = fe_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(good);
    word_due = 1'b0;
    exp_word = '0;
    if (good) begin
      mdl_bytes.push_back(b);
      if (mdl_bytes.size() == NB) begin
        word_due = 1'b1;
        exp_word = pack_word();
        mdl_bytes.delete();
      end
    end else begin
      mdl_bytes.delete();
    end
    check({tag, ".nbytes"}, 64'(obs_bytes.size() - b_base), good ? 64'd1 : 64'd0);
    if (good && obs_bytes.size() == b_base + 1)
      check({tag, ".byte"}, 64'(obs_bytes[b_base]), 64'(b));
    check({tag, ".fe"}, 64'(fe_cnt - f_base), good ? 64'd0 : 64'd1);
    check({tag, ".nwords"}, 64'(obs_words.size() - w_base), word_due ? 64'd1 : 64'd0);
    if (word_due && obs_words.size() == w_base + 1)
      check({tag, ".word"}, 64'(obs_words[w_base]), 64'(exp_word));
    check({tag, ".index"}, 64'(byte_index), 64'(mdl_bytes.size()));
    idle_bits(gap);
    if (gap >= LONG) begin
      mdl_bytes.delete();
      check({tag, ".timeout_index"}, 64'(byte_index), 64'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".byte_out"}, 64'(byte_out), 64'd0);
    check({tag, ".word_out"}, 64'(word_out), 64'd0);
    check({tag, ".strobes"}, 64'({byte_valid, word_valid, framing_error}), 64'd0);
    check({tag, ".index"}, 64'(byte_index), 64'd0);
    check({tag, ".busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int            b_base, f_base;
    logic [7:0]    rb;
    bit            good;
    int            gap, r;

    reset = 1'b1;
    rx    = 1'b1;
    repeat (4) @(negedge tb_clk_baudrate);
    check_all_zero("reset");
    reset = 1'b0;
    idle_bits(2);

    // Three bytes make one word
    do_frame("t1_f0", 8'hF0, 1'b1, 0);
    do_frame("t1_aa", 8'hAA, 1'b1, 0);
    do_frame("t1_0d", 8'h0D, 1'b1, 2);

    // Short low pulse is rejected as a glitch
    b_base = obs_bytes.size();
    f_base = fe_cnt;
    rx = 1'b0;
    repeat (3) @(negedge tb_clk_baudrate);
    rx = 1'b1;
    repeat (3 * DIV) @(negedge tb_clk_baudrate);
    check("glitch.nbytes", 64'(obs_bytes.size() - b_base), 64'd0);
    check("glitch.fe", 64'(fe_cnt - f_base), 64'd0);
    check("glitch.busy", 64'(busy), 64'd0);

    // Framing error drops the partial word
    do_frame("t4_22", 8'h22, 1'b1, 0);
    do_frame("t4_11bad", 8'h11, 1'b0, 3);
    do_frame("t4_33", 8'h33, 1'b1, 0);
    do_frame("t4_44", 8'h44, 1'b1, 1);
    do_frame("t4_55", 8'h55, 1'b1, 2);

    // Idle timeout discards 0x11 0x22
    do_frame("t5_11", 8'h11, 1'b1, 0);
    do_frame("t5_22", 8'h22, 1'b1, LONG);
    do_frame("t5_ab", 8'hAB, 1'b1, 0);
    do_frame("t5_cd", 8'hCD, 1'b1, 0);
    do_frame("t5_ef", 8'hEF, 1'b1, 2);

    // Reset in the middle of bit 4 of 0x5A, with a partial word pending
    do_frame("t6_77", 8'h77, 1'b1, 2);
    rb = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(rb[i]);
    rx = rb[4];
    repeat (DIV / 2) @(negedge tb_clk_baudrate);
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge tb_clk_baudrate);
    check_all_zero("midreset");
    repeat (3) @(negedge tb_clk_baudrate);
    reset = 1'b0;
    mdl_bytes.delete();
    idle_bits(2);
    do_frame("t6_01", 8'h01, 1'b1, 0);
    do_frame("t6_02", 8'h02, 1'b1, 0);
    do_frame("t6_03", 8'h03, 1'b1, 2);

    // Randomized frames, gaps and bad stop bits
    for (int n = 0; n < 24; n++) begin
      rb   = 8'($urandom);
      good = ($urandom_range(0, 5) != 0);
      r    = int'($urandom_range(0, 7));
      gap  = (r == 0) ? LONG : (r % 4);
      if (!good && gap < 2) gap = 2;
      do_frame($sformatf("rnd%0d", n), rb, good, gap);
    end

    idle_bits(2);
    check("strobe_overlap", 64'(overlap_cnt), 64'd0);
    check("strobe_width", 64'(long_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
